// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding instruction-memory request, redirect/stall handling.
// Optional macro FETCH_MISALIGN_TRAP_EN adds misalign_out and traps misaligned redirect targets.
package fetch_pkg;
    typedef logic [31:0] word;
    typedef enum logic {BRANCH_DISABLE = 1'b0, BRANCH_ENABLE = 1'b1} branch_en_t;
endpackage

module fetch_stage
    import fetch_pkg::*;
#(
    parameter word RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  branch_en_t branch_scs,
    input  word        branch_add_in,
    input  logic       stall_in,
    output logic       imem_req,
    output word        imem_addr,
    input  logic       imem_ready,
    input  logic       imem_rvalid,
    input  word        imem_rdata,
    output word        instr_out,
    output word        pc_out,
    output word        pc_4_out,
    output logic       valid_out
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic       misalign_out
`endif
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

    state_t state_reg;
    word    pc_reg;
    word    instr_reg;
    word    pc_out_reg;
    word    pc_4_reg;
    logic   valid_reg;
    logic   redirect;
    word    target;
    word    pc_plus_4;

    assign redirect  = (branch_scs == BRANCH_ENABLE);
    assign pc_plus_4 = pc_reg + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_reg;
    logic bad_target;
    logic pending_after;

    assign target        = branch_add_in;
    assign bad_target    = redirect && (branch_add_in[1:0] != 2'b00);
    // A request is still in flight after this edge if one is accepted now or none has answered yet.
    assign pending_after = ((state_reg == FETCH) && imem_ready) ||
                           (((state_reg == WAIT) || (state_reg == DRAIN)) && !imem_rvalid);
    assign misalign_out  = misalign_reg;
`else
    assign target = branch_add_in & ~32'h0000_0003;
`endif

    assign imem_req  = (state_reg == FETCH) && !rst;
    assign imem_addr = pc_reg;
    assign instr_out = instr_reg;
    assign pc_out    = pc_out_reg;
    assign pc_4_out  = pc_4_reg;
    assign valid_out = valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            valid_reg  <= 1'b0;
            instr_reg  <= '0;
            pc_out_reg <= '0;
            pc_4_reg   <= '0;
            // The memory does not see our reset, so an unanswered request must still be drained.
            if (((state_reg == WAIT) || (state_reg == DRAIN)) && !imem_rvalid)
                state_reg <= DRAIN;
            else
                state_reg <= FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_reg <= 1'b0;
`endif
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        else if (bad_target) begin
            misalign_reg <= 1'b1;
            valid_reg    <= 1'b0;
            state_reg    <= pending_after ? DRAIN : HOLD;
        end
`endif
        else begin
            case (state_reg)
                FETCH: begin
                    if (redirect) begin
                        pc_reg    <= target;
                        valid_reg <= 1'b0;
                        state_reg <= imem_ready ? DRAIN : FETCH;
                    end else begin
                        valid_reg <= valid_reg & stall_in;
                        if (imem_ready)
                            state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect) begin
                            pc_reg    <= target;
                            valid_reg <= 1'b0;
                            state_reg <= FETCH;
                        end else begin
                            instr_reg  <= imem_rdata;
                            pc_out_reg <= pc_reg;
                            pc_4_reg   <= pc_plus_4;
                            valid_reg  <= 1'b1;
                            pc_reg     <= pc_plus_4;
                            state_reg  <= stall_in ? HOLD : FETCH;
                        end
                    end else if (redirect) begin
                        pc_reg    <= target;
                        valid_reg <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        valid_reg <= valid_reg & stall_in;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_reg    <= target;
                        valid_reg <= 1'b0;
                        state_reg <= FETCH;
                    end else if (!stall_in) begin
                        valid_reg <= 1'b0;
                        state_reg <= FETCH;
                    end
                end
                DRAIN: begin
                    valid_reg <= 1'b0;
                    if (redirect)
                        pc_reg <= target;
                    if (imem_rvalid)
                        state_reg <= FETCH;
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized traffic
// against a request/response-level model of the fetch stage.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam word RP = 32'h0000_0100;

    logic       clk = 1'b0;
    logic       rst;
    branch_en_t branch_scs;
    word        branch_add_in;
    logic       stall_in;
    logic       imem_req;
    word        imem_addr;
    logic       imem_ready;
    logic       imem_rvalid;
    word        imem_rdata;
    word        instr_out;
    word        pc_out;
    word        pc_4_out;
    logic       valid_out;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic       misalign_out;
`endif

    fetch_stage #(.RESET_PC(RP)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_scs   (branch_scs),
        .branch_add_in(branch_add_in),
        .stall_in     (stall_in),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_4_out     (pc_4_out),
        .valid_out    (valid_out)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_out (misalign_out)
`endif
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;

    // Model: pc, whether a request is in flight, whether that request is stale,
    // whether a presented instruction is blocking further fetches, and the presented outputs.
    word  m_pc    = RP;
    logic m_out   = 1'b0;
    logic m_stale = 1'b0;
    logic m_hold  = 1'b0;
    logic m_valid = 1'b0;
    logic m_mis   = 1'b0;
    word  m_instr = '0;
    word  m_pco   = '0;
    word  m_pc4   = '0;

    logic s_req;
    word  s_addr;

    task automatic chk(input string name, input word act, input word exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check request side, advance model, check registered outputs.
    task automatic tick(input logic t_rst, input logic t_br, input word t_tgt, input logic t_stall,
                        input logic t_ready, input logic t_rvalid, input word t_rdata);
        logic req_exp;
        logic acc;
        logic mis;
        word  tgt;
        rst           = t_rst;
        branch_scs    = t_br ? BRANCH_ENABLE : BRANCH_DISABLE;
        branch_add_in = t_tgt;
        stall_in      = t_stall;
        imem_ready    = t_ready;
        imem_rvalid   = t_rvalid;
        imem_rdata    = t_rdata;
        #1;
        s_req  = imem_req;
        s_addr = imem_addr;
        req_exp = !t_rst && !m_out && !m_hold;
        chk("imem_req", {31'b0, imem_req}, {31'b0, req_exp});
        if (req_exp)
            chk("imem_addr", imem_addr, m_pc);
        acc = req_exp && t_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt = t_tgt;
        mis = t_br && (t_tgt[1:0] != 2'b00);
`else
        tgt = {t_tgt[31:2], 2'b00};
        mis = 1'b0;
`endif
        if (t_rst) begin
            m_pc = RP; m_valid = 0; m_instr = 0; m_pco = 0; m_pc4 = 0; m_hold = 0; m_mis = 0;
            if (m_out && !t_rvalid) m_stale = 1;
            else begin m_out = 0; m_stale = 0; end
        end else if (mis) begin
            m_mis = 1; m_valid = 0;
            if (acc || (m_out && !t_rvalid)) begin m_out = 1; m_stale = 1; m_hold = 0; end
            else begin m_out = 0; m_stale = 0; m_hold = 1; end
        end else if (m_hold) begin
            if (t_br) begin m_pc = tgt; m_valid = 0; m_hold = 0; end
            else if (!t_stall) begin m_valid = 0; m_hold = 0; end
        end else if (!m_out) begin
            if (t_br) begin m_pc = tgt; m_valid = 0; end
            else m_valid = m_valid & t_stall;
            if (t_ready) begin m_out = 1; m_stale = t_br; end
        end else if (m_stale) begin
            if (t_br) m_pc = tgt;
            m_valid = 0;
            if (t_rvalid) begin m_out = 0; m_stale = 0; end
        end else if (t_rvalid) begin
            m_out = 0;
            if (t_br) begin m_pc = tgt; m_valid = 0; end
            else begin
                m_instr = t_rdata; m_pco = m_pc; m_pc4 = m_pc + 32'd4;
                m_valid = 1; m_pc = m_pc + 32'd4; m_hold = t_stall;
                $display("fetch pc=%h instr=%h pc_4=%h", m_pco, m_instr, m_pc4);
            end
        end else if (t_br) begin
            m_pc = tgt; m_valid = 0; m_stale = 1;
        end else begin
            m_valid = m_valid & t_stall;
        end
        @(negedge clk);
        chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        chk("instr_out", instr_out, m_instr);
        chk("pc_out", pc_out, m_pco);
        chk("pc_4_out", pc_4_out, m_pc4);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_out", {31'b0, misalign_out}, {31'b0, m_mis});
`endif
    endtask

    initial begin
        rst = 1; branch_scs = BRANCH_DISABLE; branch_add_in = 0; stall_in = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        @(negedge clk);

        tick(1, 0, 0, 0, 1, 0, 0);
        chk("reset_req", {31'b0, s_req}, 32'd0);
        tick(1, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", {31'b0, valid_out}, 32'd0);
        chk("reset_instr", instr_out, 32'd0);

        // Zero-wait fetch from RESET_PC, with the request at 0x104 back-pressured for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                for (int k = 0; k < 3; k++) begin
                    tick(0, 0, 0, 0, 0, 0, 0);
                    chk("bp_addr", s_addr, 32'h104);
                    chk("bp_req", {31'b0, s_req}, 32'd1);
                end
            end
            tick(0, 0, 0, 0, 1, 0, 0);
            chk("seq_addr", s_addr, RP + 32'(4 * i));
            tick(0, 0, 0, 0, 0, 1, 32'h1000 + 32'(i));
            chk("seq_pc_out", pc_out, RP + 32'(4 * i));
            chk("seq_pc_4", pc_4_out, RP + 32'(4 * i) + 32'd4);
        end

        // Stall holds the instruction and blocks new requests.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 1, 32'h0050_0093);
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, 1, 1, 0, 0);
            chk("stall_instr", instr_out, 32'h0050_0093);
            chk("stall_req", {31'b0, s_req}, 32'd0);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("release_valid", {31'b0, valid_out}, 32'd0);

        // Redirect while waiting; the late response must be discarded.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(0, 1, 32'h200, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("drain_valid", {31'b0, valid_out}, 32'd0);
        chk("drain_instr", instr_out, 32'h0050_0093);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("redir_addr", s_addr, 32'h200);

        // Redirect beats stall in HOLD.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 1, 32'h1234_5678);
        tick(0, 1, 32'h200, 1, 0, 0, 0);
        chk("prio_valid", {31'b0, valid_out}, 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("prio_addr", s_addr, 32'h200);

        // PC wrap-around, then a misaligned redirect.
        tick(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("wrap_req_addr", s_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0, 0, 1, 32'h0000_0013);
        chk("wrap_pc_4", pc_4_out, 32'h0);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_addr", s_addr, 32'h0);
        tick(0, 1, 32'h202, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_flag", {31'b0, misalign_out}, 32'd1);
        chk("misalign_addr", s_addr, 32'h0);
`else
        chk("forced_align_addr", s_addr, 32'h200);
`endif

        // Reset while a request is outstanding; its response must be dropped.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        chk("rst_drain_req", {31'b0, s_req}, 32'd0);
        chk("rst_drain_valid", {31'b0, valid_out}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_br, r_stall, r_ready, r_rvalid;
            word  r_tgt;
            r_rst    = ($urandom_range(0, 99) == 0);
            r_br     = ($urandom_range(0, 9) == 0);
            r_tgt    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 3) != 0)
                r_tgt = r_tgt & ~32'h3;
            r_stall  = ($urandom_range(0, 3) == 0);
            r_ready  = ($urandom_range(0, 3) != 0);
            r_rvalid = m_out && ($urandom_range(0, 2) == 0);
            tick(r_rst, r_br, r_tgt, r_stall, r_ready, r_rvalid, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
